drc_response_misr: RTL and testbench

- Response-side companion to the scan/DRC stimulus path.
- Captures the WIDTH-bit response stream (data_out of the design under test) on a valid strobe and compacts it into a multiple-input signature register (MISR).
- After a programmed number of captured words, compares the signature against a golden value and reports pass/fail.
- Sits between the design under test and the test controller, so a multi-cycle run is checked with a single compare.

---
 rtl/drc_response_misr.sv | 111 +++++++++++
 tb/tb_drc_response_misr.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/drc_response_misr.sv
`default_nettype none
// ============================================================================
// Module      : drc_response_misr
// Description : Response MISR compactor with a single golden-signature compare
//               at the end of a run. Optional X-masking under DRC_XMASK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module drc_response_misr #(
  parameter int               WIDTH = 5,
  parameter int               CNT_W = 8,
  parameter logic [WIDTH-1:0] POLY  = 5'b00101,
  parameter logic [WIDTH-1:0] SEED  = 5'b00000
) (
  input  logic             refclk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_cycles,
  input  logic [WIDTH-1:0] golden_sig,
  input  logic             resp_valid,
  input  logic [WIDTH-1:0] resp_data,
`ifdef DRC_XMASK_EN
  input  logic [WIDTH-1:0] resp_mask,
`endif
  output logic [WIDTH-1:0] signature,
  output logic [CNT_W-1:0] cap_count,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] target;
  logic [WIDTH-1:0] golden;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] misr_next;
  logic [CNT_W-1:0] count_inc;
  logic             armable;
  logic             accept;
  logic             last_word;

`ifdef DRC_XMASK_EN
  // Masked bits are X-sources; zero them so they never reach the signature.
  assign data_in = resp_data & ~resp_mask;
`else
  assign data_in = resp_data;
`endif

  assign misr_next = {signature[WIDTH-2:0], 1'b0}
                   ^ (signature[WIDTH-1] ? POLY : '0)
                   ^ data_in;
  assign count_inc = cap_count + CNT_W'(1);
  assign armable   = (state == IDLE) || (state == DONE);
  assign accept    = (state == CAPTURE) && resp_valid;
  assign last_word = accept && (count_inc == target);

  assign busy = (state == CAPTURE) || (state == COMPARE);
  assign done = (state == DONE);

  always_ff @(posedge refclk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (start) state_next = (num_cycles == '0) ? COMPARE : CAPTURE;
      end
      CAPTURE: begin
        if (last_word) state_next = COMPARE;
      end
      COMPARE: state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge refclk) begin
    if (reset) begin
      signature <= SEED;
      cap_count <= '0;
      target    <= '0;
      golden    <= '0;
      pass      <= 1'b0;
      fail      <= 1'b0;
    end else if (armable && start) begin
      signature <= SEED;
      cap_count <= '0;
      target    <= num_cycles;
      golden    <= golden_sig;
      pass      <= 1'b0;
      fail      <= 1'b0;
    end else if (accept) begin
      signature <= misr_next;
      cap_count <= count_inc;
    end else if (state == COMPARE) begin
      pass <= (signature == golden);
      fail <= (signature != golden);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_drc_response_misr.sv
`default_nettype none
// ============================================================================
// Module      : tb_drc_response_misr
// Description : Directed self-checking bench for drc_response_misr.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_drc_response_misr;

  logic       refclk = 1'b0;
  logic       reset  = 1'b1;
  logic       start  = 1'b0;
  logic [7:0] num_cycles = '0;
  logic [4:0] golden_sig = '0;
  logic       resp_valid = 1'b0;
  logic [4:0] resp_data  = '0;
  logic [4:0] resp_mask  = '0;
  logic [4:0] signature;
  logic [7:0] cap_count;
  logic       busy, done, pass, fail;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 refclk = ~refclk;

  drc_response_misr dut (
    .refclk     (refclk),
    .reset      (reset),
    .start      (start),
    .num_cycles (num_cycles),
    .golden_sig (golden_sig),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
`ifdef DRC_XMASK_EN
    .resp_mask  (resp_mask),
`endif
    .signature  (signature),
    .cap_count  (cap_count),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .fail       (fail)
  );

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic pulse_start(input logic [7:0] n, input logic [4:0] g);
    start = 1'b1; num_cycles = n; golden_sig = g;
    tick();
    start = 1'b0; num_cycles = 8'd1; golden_sig = 5'b10101;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    n_cmp++; if (signature !== 5'b00000) begin n_bad++; $display("FAIL reset_sig got %b exp 00000", signature); end
    n_cmp++; if (cap_count !== 8'd0) begin n_bad++; $display("FAIL reset_cnt got %0d exp 0", cap_count); end
    n_cmp++; if ({busy, done, pass, fail} !== 4'b0000) begin n_bad++; $display("FAIL reset_flags got %b exp 0000", {busy, done, pass, fail}); end
  endtask

  // Five words back to back; checks each signature step and the final verdict.
  task automatic run5(input string name, input logic [4:0] w [5], input logic [4:0] s [5],
                      input logic [4:0] g, input logic exp_pass);
    pulse_start(8'd5, g);
    n_cmp++; if ({busy, done, pass, fail} !== 4'b1000) begin n_bad++; $display("FAIL %s_armed got %b exp 1000", name, {busy, done, pass, fail}); end
    for (int i = 0; i < 5; i++) begin
      resp_valid = 1'b1; resp_data = w[i];
      tick();
      n_cmp++; if (signature !== s[i]) begin n_bad++; $display("FAIL %s_step%0d got %b exp %b", name, i, signature, s[i]); end
    end
    resp_valid = 1'b0;
    n_cmp++; if ({busy, done} !== 2'b10) begin n_bad++; $display("FAIL %s_compare got %b exp 10", name, {busy, done}); end
    tick();
    n_cmp++; if ({busy, done, pass, fail} !== {2'b01, exp_pass, ~exp_pass}) begin n_bad++; $display("FAIL %s_done got %b exp %b", name, {busy, done, pass, fail}, {2'b01, exp_pass, ~exp_pass}); end
    n_cmp++; if (cap_count !== 8'd5) begin n_bad++; $display("FAIL %s_count got %0d exp 5", name, cap_count); end
  endtask

  task automatic test_match();
    logic [4:0] w [5] = '{5'b00001, 5'b00100, 5'b00011, 5'b00111, 5'b11111};
    logic [4:0] s [5] = '{5'b00001, 5'b00110, 5'b01111, 5'b11001, 5'b01000};
    run5("match", w, s, 5'b01000, 1'b1);
    resp_valid = 1'b1; resp_data = 5'b11111;
    tick(); tick();
    resp_valid = 1'b0;
    n_cmp++; if ({signature, done, pass} !== {5'b01000, 2'b11}) begin n_bad++; $display("FAIL done_frozen got %b exp 0100011", {signature, done, pass}); end
  endtask

  task automatic test_mismatch();
    logic [4:0] w [5] = '{5'b00001, 5'b00100, 5'b00011, 5'b00110, 5'b11111};
    logic [4:0] s [5] = '{5'b00001, 5'b00110, 5'b01111, 5'b11000, 5'b01010};
    run5("mismatch", w, s, 5'b01000, 1'b0);
  endtask

  task automatic test_gaps();
    logic [4:0] w [5] = '{5'b00001, 5'b00100, 5'b00011, 5'b00111, 5'b11111};
    pulse_start(8'd5, 5'b01000);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        resp_valid = 1'b0; resp_data = 5'b11111;
        for (int k = 0; k < 3; k++) begin
          start = (k == 1);
          tick();
        end
        start = 1'b0;
        n_cmp++; if ({cap_count, signature, busy} !== {8'd2, 5'b00110, 1'b1}) begin n_bad++; $display("FAIL gap_hold got %0d/%b/%b exp 2/00110/1", cap_count, signature, busy); end
      end
      resp_valid = 1'b1; resp_data = w[i];
      tick();
    end
    resp_valid = 1'b0;
    tick();
    n_cmp++; if ({signature, done, pass, fail} !== {5'b01000, 3'b110}) begin n_bad++; $display("FAIL gap_final got %b exp 01000110", {signature, done, pass, fail}); end
  endtask

  task automatic test_zero_len();
    pulse_start(8'd0, 5'b00000);
    n_cmp++; if ({busy, done, cap_count} !== {2'b10, 8'd0}) begin n_bad++; $display("FAIL zero_compare got %b exp 1000000000", {busy, done, cap_count}); end
    tick();
    n_cmp++; if ({done, pass, fail} !== 3'b110) begin n_bad++; $display("FAIL zero_done got %b exp 110", {done, pass, fail}); end
  endtask

  task automatic test_midrun_reset();
    pulse_start(8'd5, 5'b01000);
    resp_valid = 1'b1; resp_data = 5'b00001; tick();
    resp_data = 5'b00100; tick();
    n_cmp++; if ({cap_count, signature} !== {8'd2, 5'b00110}) begin n_bad++; $display("FAIL pre_reset got %0d/%b exp 2/00110", cap_count, signature); end
    reset = 1'b1; resp_data = 5'b00011;
    tick();
    reset = 1'b0; resp_valid = 1'b0;
    n_cmp++; if ({signature, cap_count, busy, done, pass, fail} !== 17'd0) begin n_bad++; $display("FAIL midrun_reset got %b exp all zero", {signature, cap_count, busy, done, pass, fail}); end
    resp_valid = 1'b1; resp_data = 5'b11111; tick(); resp_valid = 1'b0;
    n_cmp++; if ({signature, busy} !== 6'd0) begin n_bad++; $display("FAIL idle_ignore got %b exp 000000", {signature, busy}); end
  endtask

`ifdef DRC_XMASK_EN
  // Word 5 arrives as 11111 but bit 4 is masked, so 01111 is compacted.
  task automatic test_xmask();
    logic [4:0] w [5] = '{5'b00001, 5'b00100, 5'b00011, 5'b00111, 5'b11111};
    logic [4:0] s [5] = '{5'b00001, 5'b00110, 5'b01111, 5'b11001, 5'b11000};
    resp_mask = 5'b10000;
    run5("xmask", w, s, 5'b11000, 1'b1);
    resp_mask = 5'b00000;
  endtask
`endif

  initial begin
    test_reset();
    test_match();
    test_mismatch();
    test_gaps();
    test_zero_len();
    test_midrun_reset();
`ifdef DRC_XMASK_EN
    test_xmask();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
